// File: rtl/uart_pkg.sv
// Shared constants, error codes, state encoding and the CRC-8 step
// used by the UART framing logic on both receive and transmit sides.
package uart_pkg;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam logic [7:0] BCAST_ADDR = 8'hFF;
    localparam logic [7:0] CRC8_POLY  = 8'h07;

    localparam logic [1:0] ERR_CRC = 2'd0;
    localparam logic [1:0] ERR_LEN = 2'd1;
    localparam logic [1:0] ERR_TMO = 2'd2;
    localparam logic [1:0] ERR_OVR = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_DATA,
        ST_CRC
    } state_e;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        return {crc[6:0], 1'b0} ^ ((crc[7] ^ din) ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 (poly 0x07, init 0x00); one data bit per enable strobe.
// Shared by the receive framer and the transmit framer.
module crc8_serial
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [7:0] crc
);

    logic [7:0] crc_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= 8'h00;
        end else if (clr) begin
            crc_q <= 8'h00;
        end else if (en) begin
            crc_q <= crc8_step(crc_q, bit_in);
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/uart_frame_rx.sv
// Receive framer: parses SYNC/ADDR/LEN/payload/CRC8 frames from the UART,
// filters by address and holds one good frame for the command layer.
module uart_frame_rx
    import uart_pkg::*;
#(
    parameter logic [7:0] SYNC    = SYNC_BYTE,
    parameter logic [7:0] MY_ADDR = 8'h01,
    parameter int         MAX_LEN = 16,
    parameter int         TIMEOUT = 1024,
    parameter int         TW      = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] r_byte,
    input  logic       received,
    input  logic       r_bit,
    input  logic       r_bit_re,
    output logic       frame_valid,
    output logic [7:0] frame_addr,
    output logic [7:0] frame_len,
    input  logic [7:0] rd_idx,
    output logic [7:0] rd_data,
    input  logic       frame_ack,
    output logic       err,
    output logic [1:0] err_code
);

    localparam int            AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);

    state_e        state_q;
    logic [7:0]    addr_q;
    logic [7:0]    len_q;
    logic [7:0]    cnt_q;
    logic [TW-1:0] tmo_q;
    logic [7:0]    buf_q [MAX_LEN];
    logic [7:0]    crc;

    logic sof;
    logic crc_en;
    logic buf_we;
    logic tmo_hit;
    logic addr_ok;
    logic held;

    assign sof     = received && (state_q == ST_IDLE) && (r_byte == SYNC);
    assign crc_en  = r_bit_re && ((state_q == ST_ADDR) || (state_q == ST_LEN) || (state_q == ST_DATA));
    assign buf_we  = received && (state_q == ST_DATA) && !frame_valid;
    assign tmo_hit = (state_q != ST_IDLE) && !received && (tmo_q == TMO_LIMIT);
    assign addr_ok = (addr_q == MY_ADDR) || (addr_q == BCAST_ADDR);
    // An ack in the same cycle frees the slot for a frame completing now.
    assign held    = frame_valid && !frame_ack;

    crc8_serial u_crc (
        .clk    (clk),
        .rst    (rst),
        .clr    (sof),
        .en     (crc_en),
        .bit_in (r_bit),
        .crc    (crc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
        end else if (received || (state_q == ST_IDLE)) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TW'(1);
        end
    end

    // NOTE: payload storage has no reset; frame_valid=0 already marks its contents as meaningless.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[cnt_q[AW-1:0]] <= r_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= 8'h00;
        end else if (rd_idx < MAX_LEN_B) begin
            rd_data <= buf_q[rd_idx[AW-1:0]];
        end else begin
            rd_data <= 8'h00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= 8'h00;
            len_q       <= 8'h00;
            cnt_q       <= 8'h00;
            frame_valid <= 1'b0;
            frame_addr  <= 8'h00;
            frame_len   <= 8'h00;
            err         <= 1'b0;
            err_code    <= ERR_CRC;
        end else begin
            err <= 1'b0;
            if (frame_valid && frame_ack) begin
                frame_valid <= 1'b0;
            end

            if (tmo_hit) begin
                state_q  <= ST_IDLE;
                err      <= 1'b1;
                err_code <= ERR_TMO;
            end else if (received) begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (r_byte == SYNC) begin
                            state_q <= ST_ADDR;
                        end
                    end
                    ST_ADDR: begin
                        addr_q  <= r_byte;
                        state_q <= ST_LEN;
                    end
                    ST_LEN: begin
                        len_q <= r_byte;
                        cnt_q <= 8'h00;
                        if (r_byte > MAX_LEN_B) begin
                            state_q  <= ST_IDLE;
                            err      <= 1'b1;
                            err_code <= ERR_LEN;
                        end else if (r_byte == 8'h00) begin
                            state_q <= ST_CRC;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        cnt_q <= cnt_q + 8'd1;
                        if (cnt_q == len_q - 8'd1) begin
                            state_q <= ST_CRC;
                        end
                    end
                    ST_CRC: begin
                        state_q <= ST_IDLE;
                        if (r_byte != crc) begin
                            err      <= 1'b1;
                            err_code <= ERR_CRC;
                        end else if (addr_ok) begin
                            if (held) begin
                                err      <= 1'b1;
                                err_code <= ERR_OVR;
                            end else begin
                                frame_valid <= 1'b1;
                                frame_addr  <= addr_q;
                                frame_len   <= len_q;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: randomized frames against a
// frame-level reference model (CRC over bytes, accept/drop/error rules).
`timescale 1ns/1ps
module tb_uart_frame_rx;

    localparam int MAX_LEN = 16;
    localparam int TIMEOUT = 1024;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] r_byte;
    logic       received;
    logic       r_bit;
    logic       r_bit_re;
    logic       frame_valid;
    logic [7:0] frame_addr;
    logic [7:0] frame_len;
    logic [7:0] rd_idx;
    logic [7:0] rd_data;
    logic       frame_ack;
    logic       err;
    logic [1:0] err_code;

    always #5 clk = ~clk;

    uart_frame_rx dut (
        .clk         (clk),
        .rst         (rst),
        .r_byte      (r_byte),
        .received    (received),
        .r_bit       (r_bit),
        .r_bit_re    (r_bit_re),
        .frame_valid (frame_valid),
        .frame_addr  (frame_addr),
        .frame_len   (frame_len),
        .rd_idx      (rd_idx),
        .rd_data     (rd_data),
        .frame_ack   (frame_ack),
        .err         (err),
        .err_code    (err_code)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] err_log [$];
    always @(negedge clk) if (err === 1'b1) err_log.push_back(err_code);

    // Reference model state: the frame the consumer should currently see.
    bit         exp_valid;
    logic [7:0] exp_addr;
    logic [7:0] exp_len;
    logic [7:0] exp_pl [$];
    bit         exp_pl_known;

    function automatic logic [7:0] crc_of(input logic [7:0] bytes [$]);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        foreach (bytes[i]) begin
            for (int k = 0; k < 8; k++) begin
                fb = c[7] ^ bytes[i][k];
                c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return c;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            r_bit    = b[i];
            r_bit_re = 1'b1;
            tick(1);
            r_bit_re = 1'b0;
            tick(2);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ack);
        send_bits(b);
        r_byte    = b;
        received  = 1'b1;
        frame_ack = ack;
        tick(1);
        received  = 1'b0;
        frame_ack = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] addr, input logic [7:0] pl [$],
                              input logic [7:0] crc_flip, input bit ack_on_crc);
        logic [7:0] body [$];
        body = pl;
        body.push_front(8'(pl.size()));
        body.push_front(addr);
        send_byte(8'hA5, 1'b0);
        foreach (body[i]) send_byte(body[i], 1'b0);
        send_byte(crc_of(body) ^ crc_flip, ack_on_crc);
    endtask

    // Frame-level outcome: LEN limit, CRC, address filter, then single-slot hold.
    task automatic model_frame(input logic [7:0] addr, input logic [7:0] pl [$],
                               input bit crc_good, input bit ack, output int exp_err);
        bit was_valid;
        was_valid = exp_valid;
        exp_err   = -1;
        if (ack) exp_valid = 1'b0;
        if (pl.size() > MAX_LEN) exp_err = 1;
        else if (!crc_good) exp_err = 0;
        else if (!(addr == 8'h01 || addr == 8'hFF)) exp_err = -1;
        else if (exp_valid) exp_err = 3;
        else begin
            exp_valid    = 1'b1;
            exp_addr     = addr;
            exp_len      = 8'(pl.size());
            exp_pl       = pl;
            exp_pl_known = !was_valid;
        end
    endtask

    task automatic read_at(input logic [7:0] idx, output logic [7:0] d);
        rd_idx = idx;
        tick(1);
        d = rd_data;
    endtask

    task automatic do_ack();
        frame_ack = 1'b1;
        tick(1);
        frame_ack = 1'b0;
        exp_valid = 1'b0;
    endtask

    task automatic rand_payload(input int n, output logic [7:0] pl [$]);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic test_reset();
        rst = 1'b1; r_byte = 8'h00; received = 1'b0; r_bit = 1'b0;
        r_bit_re = 1'b0; rd_idx = 8'h00; frame_ack = 1'b0;
        exp_valid = 1'b0; exp_pl_known = 1'b0;
        tick(3);
        n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", frame_valid); end
        n_checks++; if (frame_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h want 00", frame_addr); end
        n_checks++; if (frame_len !== 8'h00) begin n_fail++; $display("FAIL reset_len: got %h want 00", frame_len); end
        n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_checks++; if (err_code !== 2'd0) begin n_fail++; $display("FAIL reset_err_code: got %0d want 0", err_code); end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_good_frame();
        logic [7:0] pl [$];
        logic [7:0] d;
        int e;
        for (int t = 0; t < 5; t++) begin
            if (t == 0) pl = '{8'h11, 8'h22};
            else rand_payload($urandom_range(1, MAX_LEN), pl);
            err_log.delete();
            send_frame((t % 2 == 0) ? 8'h01 : 8'hFF, pl, 8'h00, 1'b0);
            model_frame((t % 2 == 0) ? 8'h01 : 8'hFF, pl, 1'b1, 1'b0, e);
            tick(2);
            n_checks++; if (frame_valid !== exp_valid) begin n_fail++; $display("FAIL good_valid[%0d]: got %b want %b", t, frame_valid, exp_valid); end
            n_checks++; if (frame_addr !== exp_addr) begin n_fail++; $display("FAIL good_addr[%0d]: got %h want %h", t, frame_addr, exp_addr); end
            n_checks++; if (frame_len !== exp_len) begin n_fail++; $display("FAIL good_len[%0d]: got %0d want %0d", t, frame_len, exp_len); end
            n_checks++; if (err_log.size() != 0) begin n_fail++; $display("FAIL good_no_err[%0d]: got %0d pulses want 0", t, err_log.size()); end
            for (int i = 0; i < exp_pl.size(); i++) begin
                read_at(8'(i), d);
                n_checks++; if (d !== exp_pl[i]) begin n_fail++; $display("FAIL good_payload[%0d][%0d]: got %h want %h", t, i, d, exp_pl[i]); end
            end
            do_ack();
            tick(1);
            n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL good_ack[%0d]: got %b want 0", t, frame_valid); end
        end
    endtask

    task automatic test_bad_crc();
        logic [7:0] pl [$];
        int e;
        pl = '{8'h11, 8'h22};
        err_log.delete();
        send_frame(8'h01, pl, 8'hFF, 1'b0);
        model_frame(8'h01, pl, 1'b0, 1'b0, e);
        tick(2);
        n_checks++; if (frame_valid !== exp_valid) begin n_fail++; $display("FAIL crc_valid: got %b want %b", frame_valid, exp_valid); end
        n_checks++; if (err_log.size() != 1 || err_log[0] !== 2'(e)) begin n_fail++; $display("FAIL crc_err: got %0d pulses want 1 pulse code %0d", err_log.size(), e); end
    endtask

    task automatic test_frame_error_bits();
        logic [7:0] body [$];
        logic [7:0] pl [$];
        int e;
        rand_payload(1, pl);
        body = '{8'h01, 8'h01};
        body.push_back(pl[0]);
        err_log.delete();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        send_bits(8'(($urandom_range(1, 255))));
        send_byte(pl[0], 1'b0);
        send_byte(crc_of(body), 1'b0);
        model_frame(8'h01, pl, 1'b0, 1'b0, e);
        tick(2);
        n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL ferr_valid: got %b want 0", frame_valid); end
        n_checks++; if (err_log.size() != 1 || err_log[0] !== 2'(e)) begin n_fail++; $display("FAIL ferr_err: got %0d pulses want 1 pulse code %0d", err_log.size(), e); end
    endtask

    task automatic test_len();
        logic [7:0] pl [$];
        logic [7:0] d;
        int e;
        logic [7:0] bad_lens [2];
        bad_lens = '{8'h20, 8'(MAX_LEN + 1)};
        foreach (bad_lens[k]) begin
            err_log.delete();
            send_byte(8'hA5, 1'b0);
            send_byte(8'h01, 1'b0);
            send_byte(bad_lens[k], 1'b0);
            tick(2);
            n_checks++; if (err_log.size() != 1 || err_log[0] !== 2'd1) begin n_fail++; $display("FAIL len_err[%0d]: got %0d pulses want 1 pulse code 1", k, err_log.size()); end
            n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL len_valid[%0d]: got %b want 0", k, frame_valid); end
        end
        rand_payload(MAX_LEN, pl);
        err_log.delete();
        send_frame(8'h01, pl, 8'h00, 1'b0);
        model_frame(8'h01, pl, 1'b1, 1'b0, e);
        tick(2);
        n_checks++; if (frame_valid !== 1'b1 || frame_len !== 8'(MAX_LEN)) begin n_fail++; $display("FAIL len_max_accept: got valid %b len %0d want 1/%0d", frame_valid, frame_len, MAX_LEN); end
        read_at(8'(MAX_LEN - 1), d);
        n_checks++; if (d !== exp_pl[MAX_LEN-1]) begin n_fail++; $display("FAIL len_max_last: got %h want %h", d, exp_pl[MAX_LEN-1]); end
        read_at(8'(MAX_LEN), d);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL rd_out_of_range: got %h want 00", d); end
        read_at(8'hFF, d);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL rd_idx_ff: got %h want 00", d); end
        do_ack();
        pl.delete();
        err_log.delete();
        send_frame(8'h01, pl, 8'h00, 1'b0);
        model_frame(8'h01, pl, 1'b1, 1'b0, e);
        tick(2);
        n_checks++; if (frame_valid !== 1'b1 || frame_len !== 8'h00 || err_log.size() != 0) begin n_fail++; $display("FAIL len_zero: got valid %b len %0d pulses %0d want 1/0/0", frame_valid, frame_len, err_log.size()); end
        do_ack();
    endtask

    task automatic test_timeout();
        logic [7:0] pl [$];
        int waited;
        int e;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h11, 1'b0);
        err_log.delete();
        tick(TIMEOUT - 20);
        n_checks++; if (err_log.size() != 0) begin n_fail++; $display("FAIL tmo_early: got %0d pulses want 0", err_log.size()); end
        waited = 0;
        while (err_log.size() == 0 && waited < 60) begin
            tick(1);
            waited++;
        end
        tick(2);
        n_checks++; if (err_log.size() != 1 || err_log[0] !== 2'd2) begin n_fail++; $display("FAIL tmo_err: got %0d pulses want 1 pulse code 2", err_log.size()); end
        rand_payload(3, pl);
        err_log.delete();
        send_frame(8'h01, pl, 8'h00, 1'b0);
        model_frame(8'h01, pl, 1'b1, 1'b0, e);
        tick(2);
        n_checks++; if (frame_valid !== 1'b1 || frame_len !== 8'd3 || err_log.size() != 0) begin n_fail++; $display("FAIL tmo_recover: got valid %b len %0d pulses %0d want 1/3/0", frame_valid, frame_len, err_log.size()); end
        do_ack();
    endtask

    task automatic test_addr_filter();
        logic [7:0] pl [$];
        int e;
        rand_payload(4, pl);
        err_log.delete();
        send_frame(8'h05, pl, 8'h00, 1'b0);
        model_frame(8'h05, pl, 1'b1, 1'b0, e);
        tick(2);
        n_checks++; if (frame_valid !== exp_valid || err_log.size() != 0) begin n_fail++; $display("FAIL addr_drop: got valid %b pulses %0d want %b/0", frame_valid, err_log.size(), exp_valid); end
        send_frame(8'hFF, pl, 8'h00, 1'b0);
        model_frame(8'hFF, pl, 1'b1, 1'b0, e);
        tick(2);
        n_checks++; if (frame_valid !== exp_valid || frame_addr !== exp_addr || err_log.size() != 0) begin n_fail++; $display("FAIL addr_bcast: got valid %b addr %h pulses %0d want %b/%h/0", frame_valid, frame_addr, err_log.size(), exp_valid, exp_addr); end
        do_ack();
    endtask

    task automatic test_back_to_back();
        logic [7:0] pl1 [$];
        logic [7:0] pl2 [$];
        logic [7:0] d;
        int e;
        rand_payload($urandom_range(2, MAX_LEN), pl1);
        rand_payload($urandom_range(2, MAX_LEN), pl2);
        err_log.delete();
        send_frame(8'h01, pl1, 8'h00, 1'b0);
        model_frame(8'h01, pl1, 1'b1, 1'b0, e);
        send_frame(8'hFF, pl2, 8'h00, 1'b0);
        model_frame(8'hFF, pl2, 1'b1, 1'b0, e);
        tick(2);
        n_checks++; if (err_log.size() != 1 || err_log[0] !== 2'(e)) begin n_fail++; $display("FAIL ovr_err: got %0d pulses want 1 pulse code %0d", err_log.size(), e); end
        n_checks++; if (frame_valid !== exp_valid || frame_addr !== exp_addr || frame_len !== exp_len) begin n_fail++; $display("FAIL ovr_fields: got %b/%h/%0d want %b/%h/%0d", frame_valid, frame_addr, frame_len, exp_valid, exp_addr, exp_len); end
        for (int i = 0; i < exp_pl.size(); i++) begin
            read_at(8'(i), d);
            n_checks++; if (d !== exp_pl[i]) begin n_fail++; $display("FAIL ovr_payload[%0d]: got %h want %h", i, d, exp_pl[i]); end
        end
        do_ack();
        err_log.delete();
        send_frame(8'h01, pl1, 8'h00, 1'b0);
        model_frame(8'h01, pl1, 1'b1, 1'b0, e);
        send_frame(8'hFF, pl2, 8'h00, 1'b1);
        model_frame(8'hFF, pl2, 1'b1, 1'b1, e);
        tick(2);
        n_checks++; if (err_log.size() != 0) begin n_fail++; $display("FAIL ack_swap_err: got %0d pulses want 0", err_log.size()); end
        n_checks++; if (frame_valid !== exp_valid || frame_addr !== exp_addr || frame_len !== exp_len) begin n_fail++; $display("FAIL ack_swap_fields: got %b/%h/%0d want %b/%h/%0d", frame_valid, frame_addr, frame_len, exp_valid, exp_addr, exp_len); end
        do_ack();
    endtask

    task automatic test_reset_mid();
        logic [7:0] pl [$];
        logic [7:0] d;
        int e;
        rand_payload(5, pl);
        send_frame(8'h01, pl, 8'h00, 1'b0);
        model_frame(8'h01, pl, 1'b1, 1'b0, e);
        rd_idx = 8'h00;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h5A, 1'b0);
        send_byte(8'hC3, 1'b0);
        rst = 1'b1;
        #1;
        n_checks++; if (frame_valid !== 1'b0 || frame_addr !== 8'h00 || frame_len !== 8'h00) begin n_fail++; $display("FAIL rstmid_fields: got %b/%h/%0d want 0/00/0", frame_valid, frame_addr, frame_len); end
        n_checks++; if (rd_data !== 8'h00 || err !== 1'b0 || err_code !== 2'd0) begin n_fail++; $display("FAIL rstmid_outs: got rd %h err %b code %0d want 00/0/0", rd_data, err, err_code); end
        tick(2);
        rst = 1'b0;
        exp_valid = 1'b0;
        tick(1);
        rand_payload(3, pl);
        err_log.delete();
        send_frame(8'h01, pl, 8'h00, 1'b0);
        model_frame(8'h01, pl, 1'b1, 1'b0, e);
        tick(2);
        n_checks++; if (frame_valid !== 1'b1 || frame_len !== 8'd3 || err_log.size() != 0) begin n_fail++; $display("FAIL rstmid_next: got valid %b len %0d pulses %0d want 1/3/0", frame_valid, frame_len, err_log.size()); end
        read_at(8'd2, d);
        n_checks++; if (d !== exp_pl[2]) begin n_fail++; $display("FAIL rstmid_payload: got %h want %h", d, exp_pl[2]); end
        do_ack();
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_crc();
        test_frame_error_bits();
        test_len();
        test_timeout();
        test_addr_filter();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
